// File: rtl/sap_ctrl_seq.sv
// sap_ctrl_seq: controller-sequencer for the SAP datapath.
//
// A one-hot T-state ring plus a microcode decode drive the bus control lines
// of PC, MAR, RAM, IR, A, B, ALU and OUT. It supports conditional jumps
// (JMP/JZ/JC, which use the PC parallel-load strobe lp), HLT latching,
// prog_mode hold and a configurable ring length.
//
// Parameters
//   NSTATES  T-states per ring, 6..8 (states after T6 issue no control)
//   OPW      opcode width, >= 4 (any set bit above [3:0] decodes as NOP)
//
// Ports
//   clk        in   rising-edge clock
//   n_clr      in   asynchronous active-low reset
//   prog_mode  in   1 = RAM being loaded; sequencer held, outputs inactive
//   opcode     in   IR opcode [OPW-1:0]
//   flag_z     in   ALU zero flag (used by JZ in T4)
//   flag_c     in   ALU carry flag (used by JC in T4)
//   tstate     out  one-hot current T-state, bit0 = T1
//   halted     out  HLT has executed
//   cp,ep,ea,su,eu,lp               out  active-high controls
//   n_lm,n_ce,n_li,n_ei,n_la,n_lb,n_lo  out  active-low controls
//
// Configuration macro: SEQ_EARLY_END_EN
//   Defined:   the ring returns to T1 right after the last state the current
//              opcode uses (NOP after T3, JMP/JZ/JC/OUT after T4, LDA after
//              T5, ADD/SUB after T6). Fetch is never shortened.
//   Undefined: every instruction occupies all NSTATES states.
//
// Sequencer mode (exposed through halted and tstate):
//   MODE_WAIT  after reset, waiting for the first edge with prog_mode low
//   MODE_RUN   ring is running (frozen while prog_mode is high)
//   MODE_HALT  HLT executed; tstate frozen at T4 until reset
module sap_ctrl_seq #(
    parameter int NSTATES = 6,
    parameter int OPW     = 4
) (
    input  logic               clk,
    input  logic               n_clr,
    input  logic               prog_mode,
    input  logic [OPW-1:0]     opcode,
    input  logic               flag_z,
    input  logic               flag_c,
    output logic [NSTATES-1:0] tstate,
    output logic               halted,
    output logic               cp,
    output logic               ep,
    output logic               ea,
    output logic               su,
    output logic               eu,
    output logic               lp,
    output logic               n_lm,
    output logic               n_ce,
    output logic               n_li,
    output logic               n_ei,
    output logic               n_la,
    output logic               n_lb,
    output logic               n_lo
);

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_JMP = 4'b0011;
    localparam logic [3:0] OP_JZ  = 4'b0100;
    localparam logic [3:0] OP_JC  = 4'b0101;
    localparam logic [3:0] OP_NOP = 4'b0110;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [NSTATES-1:0] T1_ONEHOT = NSTATES'(1);

    typedef enum logic [1:0] {
        MODE_WAIT = 2'd0,
        MODE_RUN  = 2'd1,
        MODE_HALT = 2'd2
    } mode_e;

    mode_e              mode_q, mode_d;
    logic [NSTATES-1:0] tstate_q, tstate_d;
    logic [3:0]         op;
    logic               op_in_range;
    logic               at_end;
    logic               active;

    // Wide opcodes with anything set above bit 3 are folded onto a NOP code.
    assign op_in_range = ((opcode >> 4) == '0);
    assign op          = op_in_range ? opcode[3:0] : OP_NOP;

    // at_end: the current T-state is the last one of this instruction.
    always_comb begin
`ifdef SEQ_EARLY_END_EN
        case (op)
            OP_LDA:                       at_end = tstate_q[4];
            OP_ADD, OP_SUB:               at_end = tstate_q[5];
            OP_JMP, OP_JZ, OP_JC, OP_OUT: at_end = tstate_q[3];
            OP_HLT:                       at_end = tstate_q[NSTATES-1];
            default:                      at_end = tstate_q[2];
        endcase
`else
        at_end = tstate_q[NSTATES-1];
`endif
    end

    always_comb begin
        mode_d   = mode_q;
        tstate_d = tstate_q;
        case (mode_q)
            MODE_WAIT: begin
                // First edge with prog_mode low only arms the ring; T1 stays.
                if (!prog_mode) mode_d = MODE_RUN;
            end
            MODE_RUN: begin
                if (!prog_mode) begin
                    if (op == OP_HLT && tstate_q[3]) mode_d = MODE_HALT;
                    else if (at_end)                 tstate_d = T1_ONEHOT;
                    else                             tstate_d = tstate_q << 1;
                end
            end
            default: ;  // halted: everything frozen until reset
        endcase
    end

    always_ff @(posedge clk or negedge n_clr) begin
        if (!n_clr) begin
            mode_q   <= MODE_WAIT;
            tstate_q <= T1_ONEHOT;
        end else begin
            mode_q   <= mode_d;
            tstate_q <= tstate_d;
        end
    end

    assign tstate = tstate_q;
    assign halted = (mode_q == MODE_HALT);
    assign active = (mode_q == MODE_RUN) && !prog_mode;

    // Control decode. Flags only matter in T4 (JZ/JC).
    always_comb begin
        cp = 1'b0; ep = 1'b0; ea = 1'b0; su = 1'b0; eu = 1'b0; lp = 1'b0;
        n_lm = 1'b1; n_ce = 1'b1; n_li = 1'b1; n_ei = 1'b1;
        n_la = 1'b1; n_lb = 1'b1; n_lo = 1'b1;
        if (active) begin
            if (tstate_q[0]) begin
                ep = 1'b1; n_lm = 1'b0;
            end else if (tstate_q[1]) begin
                cp = 1'b1;
            end else if (tstate_q[2]) begin
                n_ce = 1'b0; n_li = 1'b0;
            end else if (tstate_q[3]) begin
                case (op)
                    OP_LDA, OP_ADD, OP_SUB: begin n_ei = 1'b0; n_lm = 1'b0; end
                    OP_JMP: begin n_ei = 1'b0; lp = 1'b1; end
                    OP_JZ:  if (flag_z) begin n_ei = 1'b0; lp = 1'b1; end
                    OP_JC:  if (flag_c) begin n_ei = 1'b0; lp = 1'b1; end
                    OP_OUT: begin ea = 1'b1; n_lo = 1'b0; end
                    default: ;
                endcase
            end else if (tstate_q[4]) begin
                case (op)
                    OP_LDA:         begin n_ce = 1'b0; n_la = 1'b0; end
                    OP_ADD, OP_SUB: begin n_ce = 1'b0; n_lb = 1'b0; end
                    default: ;
                endcase
            end else if (tstate_q[5]) begin
                case (op)
                    OP_ADD: begin eu = 1'b1; n_la = 1'b0; end
                    OP_SUB: begin eu = 1'b1; su = 1'b1; n_la = 1'b0; end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sap_ctrl_seq.sv
// Bench for sap_ctrl_seq: a 6-state/4-bit-opcode instance and an
// 8-state/5-bit-opcode instance share the same stimulus.
// Handshake: none; inputs are driven on the falling edge, outputs sampled
// 1 time unit later, state advances on the rising edge.
module tb_sap_ctrl_seq;

  localparam logic [12:0] INACT = 13'b000000_1111111;
  localparam logic [12:0] T1W   = {6'b010000, ~7'b1000000};
  localparam logic [12:0] T2W   = {6'b100000, ~7'b0000000};
  localparam logic [12:0] T3W   = {6'b000000, ~7'b0110000};
  localparam logic [12:0] LDA4W = {6'b000000, ~7'b1001000};
  localparam logic [12:0] LDA5W = {6'b000000, ~7'b0100100};
  localparam logic [12:0] ADD5W = {6'b000000, ~7'b0100010};
  localparam logic [12:0] ADD6W = {6'b000010, ~7'b0000100};
  localparam logic [12:0] SUB6W = {6'b000110, ~7'b0000100};
  localparam logic [12:0] JMP4W = {6'b000001, ~7'b0001000};
  localparam logic [12:0] OUT4W = {6'b001000, ~7'b0000001};

  logic clk = 1'b0;
  logic n_clr, prog_mode, flag_z, flag_c;
  logic [4:0] opcode;

  logic [5:0] t6;
  logic [7:0] t8;
  logic h6, h8;
  logic cp6, ep6, ea6, su6, eu6, lp6, n_lm6, n_ce6, n_li6, n_ei6, n_la6, n_lb6, n_lo6;
  logic cp8, ep8, ea8, su8, eu8, lp8, n_lm8, n_ce8, n_li8, n_ei8, n_la8, n_lb8, n_lo8;
  logic [12:0] w6, w8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sap_ctrl_seq #(.NSTATES(6), .OPW(4)) u6 (
    .clk(clk), .n_clr(n_clr), .prog_mode(prog_mode), .opcode(opcode[3:0]),
    .flag_z(flag_z), .flag_c(flag_c), .tstate(t6), .halted(h6),
    .cp(cp6), .ep(ep6), .ea(ea6), .su(su6), .eu(eu6), .lp(lp6),
    .n_lm(n_lm6), .n_ce(n_ce6), .n_li(n_li6), .n_ei(n_ei6),
    .n_la(n_la6), .n_lb(n_lb6), .n_lo(n_lo6)
  );

  sap_ctrl_seq #(.NSTATES(8), .OPW(5)) u8 (
    .clk(clk), .n_clr(n_clr), .prog_mode(prog_mode), .opcode(opcode),
    .flag_z(flag_z), .flag_c(flag_c), .tstate(t8), .halted(h8),
    .cp(cp8), .ep(ep8), .ea(ea8), .su(su8), .eu(eu8), .lp(lp8),
    .n_lm(n_lm8), .n_ce(n_ce8), .n_li(n_li8), .n_ei(n_ei8),
    .n_la(n_la8), .n_lb(n_lb8), .n_lo(n_lo8)
  );

  assign w6 = {cp6, ep6, ea6, su6, eu6, lp6, n_lm6, n_ce6, n_li6, n_ei6, n_la6, n_lb6, n_lo6};
  assign w8 = {cp8, ep8, ea8, su8, eu8, lp8, n_lm8, n_ce8, n_li8, n_ei8, n_la8, n_lb8, n_lo8};

  // ---------------- reference model ----------------
  typedef struct {
    bit started;
    bit halted;
    int step;     // 0-based T-state index
  } mstate_t;

  mstate_t m6, m8;

  // Last 0-based T-state used by an instruction before the ring wraps.
  function automatic int last_step(input int code, input int n);
`ifdef SEQ_EARLY_END_EN
    case (code)
      0:             return 4;
      1, 2:          return 5;
      3, 4, 5, 14:   return 3;
      15:            return n - 1;
      default:       return 2;
    endcase
`else
    return n - 1;
`endif
  endfunction

  function automatic logic [12:0] exp_word(input mstate_t m, input int code,
                                           input bit pm, input bit fz, input bit fc);
    if (!m.started || m.halted || pm) return INACT;
    case (m.step)
      0: return T1W;
      1: return T2W;
      2: return T3W;
      3: case (code)
           0, 1, 2: return LDA4W;
           3:       return JMP4W;
           4:       return fz ? JMP4W : INACT;
           5:       return fc ? JMP4W : INACT;
           14:      return OUT4W;
           default: return INACT;
         endcase
      4: case (code)
           0:       return LDA5W;
           1, 2:    return ADD5W;
           default: return INACT;
         endcase
      5: case (code)
           1:       return ADD6W;
           2:       return SUB6W;
           default: return INACT;
         endcase
      default: return INACT;
    endcase
  endfunction

  function automatic mstate_t next_m(input mstate_t m, input int code, input int n, input bit pm);
    mstate_t r = m;
    if (!r.started) begin
      if (!pm) r.started = 1'b1;
    end else if (!r.halted && !pm) begin
      if (code == 15 && r.step == 3) r.halted = 1'b1;
      else if (r.step == last_step(code, n)) r.step = 0;
      else r.step = r.step + 1;
    end
    return r;
  endfunction

  function automatic mstate_t reset_m();
    mstate_t r;
    r.started = 1'b0;
    r.halted  = 1'b0;
    r.step    = 0;
    return r;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_model();
    int c6;
    int c8;
    c6 = int'(opcode[3:0]);
    c8 = int'(opcode);
    chk("rnd_t6", 32'(t6), 32'(1) << m6.step);
    chk("rnd_h6", 32'(h6), 32'(m6.halted));
    chk("rnd_w6", 32'(w6), 32'(exp_word(m6, c6, prog_mode, flag_z, flag_c)));
    chk("rnd_t8", 32'(t8), 32'(1) << m8.step);
    chk("rnd_h8", 32'(h8), 32'(m8.halted));
    chk("rnd_w8", 32'(w8), 32'(exp_word(m8, c8, prog_mode, flag_z, flag_c)));
  endtask

  // ---------------- driver tasks ----------------
  // One full clock: rising edge (model steps with the same inputs), then
  // back on the falling edge ready for new inputs.
  task automatic tick();
    @(posedge clk);
    if (n_clr) begin
      m6 = next_m(m6, int'(opcode[3:0]), 6, prog_mode);
      m8 = next_m(m8, int'(opcode), 8, prog_mode);
    end
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Reset, load inputs, release and take the idle arming edge: on return
  // both instances sit in T1 with decode enabled.
  task automatic begin_instr(input logic [4:0] op, input logic fz, input logic fc);
    n_clr = 1'b0;
    m6 = reset_m();
    m8 = reset_m();
    opcode = op; flag_z = fz; flag_c = fc; prog_mode = 1'b0;
    @(negedge clk);
    n_clr = 1'b1;
    #1;
    chk("arm_idle_w", 32'(w6), 32'(INACT));
    tick();
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic [4:0]  op;
    logic        fz;
    logic        fc;
    logic [12:0] w4;
    logic [12:0] w5;
    logic [12:0] w6x;
    int          last;   // last T-state used (1-based) when rings end early
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{5'd0,  1'b0, 1'b0, LDA4W, LDA5W, INACT, 5};
    vecs[1]  = '{5'd1,  1'b0, 1'b0, LDA4W, ADD5W, ADD6W, 6};
    vecs[2]  = '{5'd2,  1'b1, 1'b1, LDA4W, ADD5W, SUB6W, 6};
    vecs[3]  = '{5'd3,  1'b0, 1'b0, JMP4W, INACT, INACT, 4};
    vecs[4]  = '{5'd4,  1'b1, 1'b0, JMP4W, INACT, INACT, 4};
    vecs[5]  = '{5'd4,  1'b0, 1'b1, INACT, INACT, INACT, 4};
    vecs[6]  = '{5'd5,  1'b0, 1'b1, JMP4W, INACT, INACT, 4};
    vecs[7]  = '{5'd5,  1'b1, 1'b0, INACT, INACT, INACT, 4};
    vecs[8]  = '{5'd14, 1'b0, 1'b0, OUT4W, INACT, INACT, 4};
    vecs[9]  = '{5'd7,  1'b0, 1'b0, INACT, INACT, INACT, 3};
    vecs[10] = '{5'd9,  1'b1, 1'b1, INACT, INACT, INACT, 3};

    n_clr = 1'b0; prog_mode = 1'b0; opcode = '0; flag_z = 1'b0; flag_c = 1'b0;
    m6 = reset_m();
    m8 = reset_m();
    @(negedge clk);
    #1;
    chk("reset_t6", 32'(t6), 32'd1);
    chk("reset_h6", 32'(h6), 32'd0);
    chk("reset_w6", 32'(w6), 32'(INACT));
    chk("reset_t8", 32'(t8), 32'd1);

    // Table: one instruction per row through the 6-state instance.
    for (int r = 0; r < 11; r++) begin
      logic [12:0] ew[6];
      int endk;
      ew[0] = T1W; ew[1] = T2W; ew[2] = T3W;
      ew[3] = vecs[r].w4; ew[4] = vecs[r].w5; ew[5] = vecs[r].w6x;
`ifdef SEQ_EARLY_END_EN
      endk = vecs[r].last;
`else
      endk = 6;
`endif
      begin_instr(vecs[r].op, vecs[r].fz, vecs[r].fc);
      for (int k = 0; k < endk; k++) begin
        #1;
        chk("vec_t", 32'(t6), 32'(1) << k);
        chk("vec_w", 32'(w6), 32'(ew[k]));
        tick();
      end
      #1;
      chk("vec_wrap_t", 32'(t6), 32'd1);
      chk("vec_wrap_w", 32'(w6), 32'(T1W));
    end

    // ADD on the 8-state instance: T7/T8 idle unless the ring ends early.
    begin_instr(5'd1, 1'b0, 1'b0);
    ticks(5);
    #1;
    chk("add8_t6", 32'(t8), 32'h20);
    chk("add8_w6", 32'(w8), 32'(ADD6W));
    tick();
`ifdef SEQ_EARLY_END_EN
    #1;
    chk("add8_wrap", 32'(t8), 32'd1);
`else
    #1;
    chk("add8_t7", 32'(t8), 32'h40);
    chk("add8_w7", 32'(w8), 32'(INACT));
    tick();
    #1;
    chk("add8_t8", 32'(t8), 32'h80);
    chk("add8_w8", 32'(w8), 32'(INACT));
    tick();
    #1;
    chk("add8_wrap", 32'(t8), 32'd1);
`endif

    // Opcode 10001: ADD on the narrow instance, NOP on the wide one.
    begin_instr(5'b10001, 1'b0, 1'b0);
    ticks(3);
    #1;
    chk("wide_nop_t", 32'(t8), 32'h8);
    chk("wide_nop_w", 32'(w8), 32'(INACT));
    chk("narrow_add_w", 32'(w6), 32'(LDA4W));

    // HLT: halts at end of T4 and stays there.
    begin_instr(5'd15, 1'b0, 1'b0);
    ticks(3);
    #1;
    chk("hlt_t4", 32'(t6), 32'h8);
    chk("hlt_t4_w", 32'(w6), 32'(INACT));
    chk("hlt_pre_h", 32'(h6), 32'd0);
    tick();
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("hlt_h", 32'(h6), 32'd1);
      chk("hlt_t", 32'(t6), 32'h8);
      chk("hlt_w", 32'(w6), 32'(INACT));
      tick();
    end

    // prog_mode held in T2 for 5 clocks.
    begin_instr(5'd0, 1'b0, 1'b0);
    tick();
    prog_mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("prog_t", 32'(t6), 32'h2);
      chk("prog_w", 32'(w6), 32'(INACT));
      tick();
    end
    prog_mode = 1'b0;
    #1;
    chk("prog_resume_w", 32'(w6), 32'(T2W));
    tick();
    #1;
    chk("prog_resume_t3", 32'(t6), 32'h4);

    // prog_mode high out of reset keeps the sequencer unarmed.
    n_clr = 1'b0; prog_mode = 1'b1;
    m6 = reset_m(); m8 = reset_m();
    @(negedge clk);
    n_clr = 1'b1;
    ticks(2);
    prog_mode = 1'b0;
    #1;
    chk("prog_arm_w", 32'(w6), 32'(INACT));
    tick();
    #1;
    chk("prog_arm_t1", 32'(w6), 32'(T1W));

    // Reset in the middle of T5.
    begin_instr(5'd0, 1'b0, 1'b0);
    ticks(4);
    #1;
    chk("mid_t5", 32'(t6), 32'h10);
    n_clr = 1'b0;
    m6 = reset_m(); m8 = reset_m();
    #1;
    chk("mid_rst_t", 32'(t6), 32'd1);
    chk("mid_rst_h", 32'(h6), 32'd0);
    chk("mid_rst_w", 32'(w6), 32'(INACT));
    @(negedge clk);
    n_clr = 1'b1;
    #1;
    chk("mid_rel_idle", 32'(w6), 32'(INACT));
    tick();
    #1;
    chk("mid_rel_t1", 32'(w6), 32'(T1W));

    // Random stimulus against the reference model.
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] op;
      op = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 99) < 3) op = 5'd15;
      else if (op[3:0] == 4'hF) op[0] = 1'b0;
      opcode    = op;
      flag_z    = 1'($urandom_range(0, 1));
      flag_c    = 1'($urandom_range(0, 1));
      prog_mode = ($urandom_range(0, 9) == 0);
      n_clr     = ($urandom_range(0, 49) != 0);
      if (!n_clr) begin
        m6 = reset_m();
        m8 = reset_m();
      end
      #1;
      check_model();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
